// File: rtl/run_filter_pkg.sv
// Shared types and constants for the run-length input qualifier.
package run_filter_pkg;

    // Width of the per-channel run counter
    localparam int CNT_W = 8;

    // Largest run length the counter can qualify
    localparam int MAX_COUNT = (1 << CNT_W) - 1;

    // Per-channel qualifier state; 2'b11 is unused and recovers to S_INIT
    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_HI   = 2'b01,
        S_LO   = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    // True when a run-length parameter is representable and non-zero
    function automatic bit count_ok(input int n);
        return (n >= 1) && (n <= MAX_COUNT);
    endfunction

endpackage

// File: rtl/run_filter_fsm_if.sv
// Bundle of sample inputs and qualified outputs for run_filter_fsm.
interface run_filter_fsm_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   in_vec;
    logic                  sample_en;
    logic                  sclr;
    logic [CHANNELS-1:0]   out_vec;
    logic [CHANNELS-1:0]   assert_pulse;
    logic [CHANNELS-1:0]   deassert_pulse;
    logic [2*CHANNELS-1:0] state_vec;

    // Source side: drives samples and control, observes results
    modport master (
        output in_vec, sample_en, sclr,
        input  out_vec, assert_pulse, deassert_pulse, state_vec
    );

    // Filter side
    modport slave (
        input  in_vec, sample_en, sclr,
        output out_vec, assert_pulse, deassert_pulse, state_vec
    );
endinterface

// File: rtl/run_filter_chan.sv
// One channel of the run-length qualifier: a level must persist for a
// programmable number of samples before the channel changes state.
module run_filter_chan
    import run_filter_pkg::*;
#(
    parameter int LOW_COUNT  = 3,
    parameter int HIGH_COUNT = 2
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   in_bit,
    input  logic   sample_en,
    input  logic   sclr,
    output state_t state,
    output logic   assert_pulse,
    output logic   deassert_pulse
);

    localparam logic [CNT_W-1:0] LOW_TH  = CNT_W'(LOW_COUNT);
    localparam logic [CNT_W-1:0] HIGH_TH = CNT_W'(HIGH_COUNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             last_q, last_d;
    logic             ap_q, ap_d, dp_q, dp_d;

    assign cnt_inc        = cnt_q + ONE;
    assign state          = state_q;
    assign assert_pulse   = ap_q;
    assign deassert_pulse = dp_q;

    // State, run counter, last sampled level and pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ap_q    <= 1'b0;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ap_q    <= ap_d;
            dp_q    <= dp_d;
        end
    end

    // Next-state, counter and pulse decode; pulses only fire on sampled edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ap_d    = 1'b0;
        dp_d    = 1'b0;
        if (sclr) begin
            state_d = S_INIT;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (state_q == S_BAD) begin
            state_d = S_INIT;
            cnt_d   = '0;
        end else if (sample_en) begin
            last_d = in_bit;
            case (state_q)
                S_INIT: begin
                    if (cnt_q == '0 || in_bit != last_q) cnt_d = ONE;
                    else                                 cnt_d = cnt_inc;
                    if (in_bit && cnt_d >= HIGH_TH) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                    end else if (!in_bit && cnt_d >= LOW_TH) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                        ap_d    = 1'b1;
                    end
                end
                S_HI: begin
                    if (in_bit) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= LOW_TH) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                        ap_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LO: begin
                    if (!in_bit) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= HIGH_TH) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                        dp_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/run_filter_fsm.sv
// Multi-channel run-length input qualifier: one independent filter per
// input bit, reporting qualified level, state code and edge pulses.
module run_filter_fsm
    import run_filter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int LOW_COUNT  = 3,
    parameter int HIGH_COUNT = 2
) (
    input  logic           CLK,
    input  logic           RST,
    run_filter_fsm_if.slave bus
);

    // Run lengths must fit the counter and be non-zero
    if (!count_ok(LOW_COUNT) || !count_ok(HIGH_COUNT)) begin : g_bad_count
        $fatal(1, "run_filter_fsm: LOW_COUNT and HIGH_COUNT must be 1..255");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_t st;

        run_filter_chan #(
            .LOW_COUNT  (LOW_COUNT),
            .HIGH_COUNT (HIGH_COUNT)
        ) u_chan (
            .CLK            (CLK),
            .RST            (RST),
            .in_bit         (bus.in_vec[i]),
            .sample_en      (bus.sample_en),
            .sclr           (bus.sclr),
            .state          (st),
            .assert_pulse   (bus.assert_pulse[i]),
            .deassert_pulse (bus.deassert_pulse[i])
        );

        assign bus.out_vec[i]          = (st == S_LO);
        assign bus.state_vec[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_run_filter_fsm.sv
// Directed bench for run_filter_fsm: a default-parameter instance for the
// run-length scenarios and a LOW=HIGH=1 instance against a legacy model.
module tb_run_filter_fsm;

    localparam logic [1:0] M_INIT = 2'b00;
    localparam logic [1:0] M_HI   = 2'b01;
    localparam logic [1:0] M_LO   = 2'b10;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] m_state [4];

    run_filter_fsm_if #(.CHANNELS(4)) bus0 ();
    run_filter_fsm_if #(.CHANNELS(4)) bus1 ();

    run_filter_fsm #(.CHANNELS(4), .LOW_COUNT(3), .HIGH_COUNT(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    run_filter_fsm #(.CHANNELS(4), .LOW_COUNT(1), .HIGH_COUNT(1)) dut_legacy (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input bit legacy, input logic [7:0] sv,
                            input logic [3:0] ov, input logic [3:0] ap, input logic [3:0] dp);
        if (legacy) begin
            checkOutput({tag, ".state"},    32'(bus1.state_vec),      32'(sv));
            checkOutput({tag, ".out"},      32'(bus1.out_vec),        32'(ov));
            checkOutput({tag, ".assert"},   32'(bus1.assert_pulse),   32'(ap));
            checkOutput({tag, ".deassert"}, 32'(bus1.deassert_pulse), 32'(dp));
        end else begin
            checkOutput({tag, ".state"},    32'(bus0.state_vec),      32'(sv));
            checkOutput({tag, ".out"},      32'(bus0.out_vec),        32'(ov));
            checkOutput({tag, ".assert"},   32'(bus0.assert_pulse),   32'(ap));
            checkOutput({tag, ".deassert"}, 32'(bus0.deassert_pulse), 32'(dp));
        end
    endtask

    task automatic applyStimulus(input logic [3:0] in, input logic en, input logic clr);
        bus0.in_vec    = in;
        bus0.sample_en = en;
        bus0.sclr      = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic applyLegacy(input logic [3:0] in, input logic en, input logic clr);
        bus1.in_vec    = in;
        bus1.sample_en = en;
        bus1.sclr      = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] rin, eap, edp, eov;
        logic [7:0] esv;
        logic       ren, rclr;
        logic [1:0] nxt;

        bus0.in_vec = '0; bus0.sample_en = 1'b0; bus0.sclr = 1'b0;
        bus1.in_vec = '0; bus1.sample_en = 1'b0; bus1.sclr = 1'b0;
        for (int c = 0; c < 4; c++) m_state[c] = M_INIT;

        #1;
        checkAll("reset", 1'b0, 8'h00, 4'h0, 4'h0, 4'h0);
        checkAll("reset_legacy", 1'b1, 8'h00, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        $display("[TB] Test 1: two high samples qualify S_HI");
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t1_e1", 1'b0, 8'h00, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t1_e2", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);

        $display("[TB] Test 2: broken low run on ch0");
        applyStimulus(4'hE, 1'b1, 1'b0);
        checkAll("t2_e1", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        checkAll("t2_e2", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t2_e3", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        checkAll("t2_e5", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        checkAll("t2_e6", 1'b0, 8'h56, 4'h1, 4'h1, 4'h0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        checkAll("t2_e7", 1'b0, 8'h56, 4'h1, 4'h0, 4'h0);

        $display("[TB] Test 3: high run with a held sample");
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t3_e1", 1'b0, 8'h56, 4'h1, 4'h0, 4'h0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkAll("t3_e2", 1'b0, 8'h56, 4'h1, 4'h0, 4'h0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t3_e3", 1'b0, 8'h55, 4'h0, 4'h0, 4'h1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkAll("t3_e4", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);

        $display("[TB] Test 4: all channels qualify low together");
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t4_e2", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t4_e3", 1'b0, 8'hAA, 4'hF, 4'hF, 4'h0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t4_e4", 1'b0, 8'hAA, 4'hF, 4'h0, 4'h0);

        $display("[TB] Test 5: reset mid-run discards partial count");
        applyStimulus(4'hF, 1'b1, 1'b0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkAll("t5_hi", 1'b0, 8'h55, 4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t5_cnt2", 1'b0, 8'h55, 4'h0, 4'h0, 4'h0);
        #2;
        RST = 1'b1;
        #1;
        checkAll("t5_async", 1'b0, 8'h00, 4'h0, 4'h0, 4'h0);
        #1;
        RST = 1'b0;
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t5_req2", 1'b0, 8'h00, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkAll("t5_req3", 1'b0, 8'hAA, 4'hF, 4'hF, 4'h0);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkAll("t5_sclr", 1'b0, 8'h00, 4'h0, 4'h0, 4'h0);

        $display("[TB] Test 6: LOW=HIGH=1 against legacy model");
        for (int i = 0; i < 40; i++) begin
            rin  = 4'($urandom_range(0, 15));
            ren  = ($urandom_range(0, 3) != 0);
            rclr = (i == 20 || i == 33);
            eap  = '0;
            edp  = '0;
            for (int c = 0; c < 4; c++) begin
                if (rclr)     nxt = M_INIT;
                else if (ren) nxt = rin[c] ? M_HI : M_LO;
                else          nxt = m_state[c];
                eap[c] = !rclr && ren && nxt == M_LO && m_state[c] != M_LO;
                edp[c] = !rclr && ren && nxt == M_HI && m_state[c] == M_LO;
                m_state[c] = nxt;
            end
            esv = {m_state[3], m_state[2], m_state[1], m_state[0]};
            for (int c = 0; c < 4; c++) eov[c] = (m_state[c] == M_LO);
            applyLegacy(rin, ren, rclr);
            checkAll(rclr ? "t6_sclr" : "t6_rand", 1'b1, esv, eov, eap, edp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
